// File: rtl/uart_echo_ctrl_if.sv
// Signal bundle between the echo controller and its UART RX/TX neighbours.
// The controller takes the slave view; the board top or a bench drives the master view.
interface uart_echo_ctrl_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_BITS  = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [DATA_BITS-1:0] rx_data_in;
  logic                 rx_valid_in;
  logic                 tx_done_in;
  logic                 enable_in;
  logic                 clr_overflow_in;
  logic [DATA_BITS-1:0] tx_data_out;
  logic                 tx_start_out;
  logic [LW-1:0]        fifo_level_out;
  logic                 full_out;
  logic                 empty_out;
  logic                 overflow_out;
  logic [CNT_BITS-1:0]  drop_count_out;

  modport master (
    output rx_data_in, rx_valid_in, tx_done_in, enable_in, clr_overflow_in,
    input  tx_data_out, tx_start_out, fifo_level_out, full_out, empty_out,
           overflow_out, drop_count_out
  );

  modport slave (
    input  rx_data_in, rx_valid_in, tx_done_in, enable_in, clr_overflow_in,
    output tx_data_out, tx_start_out, fifo_level_out, full_out, empty_out,
           overflow_out, drop_count_out
  );
endinterface

// File: rtl/uart_echo_ctrl.sv
// Echo controller: buffers UART RX bytes in a FIFO and replays them to TX with a start/done handshake.
// Write-to-start is 2 cycles; RX is never stalled, so a write into a full FIFO is dropped and counted.
module uart_echo_ctrl #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MODE       = 0,
  parameter int unsigned TERM_CHAR  = 8'h0D,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned CNT_BITS   = 16
) (
  input logic             sysclk,
  input logic             rst_in,
  uart_echo_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DATA_BITS-1:0] TERM     = DATA_BITS'(TERM_CHAR);
  localparam logic [LW-1:0]        FULL_LVL = LW'(DEPTH);
  localparam logic [GW-1:0]        GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic [LW-1:0]        pending_lines;
  logic                 rx_valid_q;
  logic                 flush;
  logic [1:0]           state;
  logic [GW-1:0]        gap_cnt;

  logic                 wr_evt;
  logic                 push;
  logic                 drop;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 eligible;
  logic                 push_term;
  logic                 pop_term;
  logic [DATA_BITS-1:0] head;

  // A held-high rx_valid_in must produce exactly one write, so only its rising edge counts.
  assign wr_evt = bus.rx_valid_in & ~rx_valid_q;
  assign full   = (level == FULL_LVL);
  assign empty  = (level == '0);
  assign push   = wr_evt & ~full;
  assign drop   = wr_evt & full;
  assign head   = mem[rd_ptr];

  assign eligible  = bus.enable_in & ~empty & ((MODE == 0) | (pending_lines != '0) | flush);
  assign pop       = (state == S_IDLE) & eligible;
  assign push_term = push & (bus.rx_data_in == TERM);
  assign pop_term  = pop & (head == TERM);

  assign bus.fifo_level_out = level;
  assign bus.full_out       = full;
  assign bus.empty_out      = empty;

  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= bus.rx_valid_in;
    end
  end

  // Storage is not reset: contents are meaningless once the pointers are cleared.
  always_ff @(posedge sysclk) begin
    if (push) begin
      mem[wr_ptr] <= bus.rx_data_in;
    end
  end

  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  // Line mode: a FIFO filled without any terminator would deadlock, so it is flushed until empty.
  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      pending_lines <= '0;
      flush         <= 1'b0;
    end else begin
      if (push_term && !pop_term) begin
        pending_lines <= pending_lines + LW'(1);
      end else if (pop_term && !push_term) begin
        pending_lines <= pending_lines - LW'(1);
      end
      if (empty) begin
        flush <= 1'b0;
      end else if (full && (pending_lines == '0)) begin
        flush <= 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      bus.overflow_out   <= 1'b0;
      bus.drop_count_out <= '0;
    end else if (bus.clr_overflow_in) begin
      bus.overflow_out   <= 1'b0;
      bus.drop_count_out <= '0;
    end else if (drop) begin
      bus.overflow_out <= 1'b1;
      if (bus.drop_count_out != '1) begin
        bus.drop_count_out <= bus.drop_count_out + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      state            <= S_IDLE;
      gap_cnt          <= '0;
      bus.tx_data_out  <= '0;
      bus.tx_start_out <= 1'b0;
    end else begin
      bus.tx_start_out <= (state == S_START);
      case (state)
        S_IDLE: begin
          if (pop) begin
            bus.tx_data_out <= head;
            state           <= S_START;
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.tx_done_in) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GAP_LAST;
              state   <= S_GAP;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Bench for uart_echo_ctrl: char-mode, line-mode and gap-timed instances share RX stimulus;
// a queue model of stored bytes is compared against the bytes each TX start carries.
module tb_uart_echo_ctrl;
  localparam int DB  = 8;
  localparam int DEP = 16;
  localparam int CB  = 16;
  localparam int GAP = 5;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  logic [7:0]  rx_data  = 8'h00;
  logic        rx_valid = 1'b0;
  logic [2:0]  en       = 3'b000;
  logic        clr      = 1'b0;
  logic [2:0]  done_r   = 3'b000;
  logic [2:0]  start_w;
  logic [7:0]  txd_w  [3];
  logic [4:0]  lvl_w  [3];
  logic [2:0]  full_w;
  logic [2:0]  empty_w;
  logic [2:0]  ovf_w;
  logic [15:0] drop_w [3];

  uart_echo_ctrl_if #(.DATA_BITS(DB), .DEPTH(DEP), .CNT_BITS(CB)) bus_c ();
  uart_echo_ctrl_if #(.DATA_BITS(DB), .DEPTH(DEP), .CNT_BITS(CB)) bus_l ();
  uart_echo_ctrl_if #(.DATA_BITS(DB), .DEPTH(DEP), .CNT_BITS(CB)) bus_g ();

`define HOOK(B, I) \
  assign B.rx_data_in      = rx_data; \
  assign B.rx_valid_in     = rx_valid; \
  assign B.tx_done_in      = done_r[I]; \
  assign B.enable_in       = en[I]; \
  assign B.clr_overflow_in = clr; \
  assign start_w[I]        = B.tx_start_out; \
  assign txd_w[I]          = B.tx_data_out; \
  assign lvl_w[I]          = B.fifo_level_out; \
  assign full_w[I]         = B.full_out; \
  assign empty_w[I]        = B.empty_out; \
  assign ovf_w[I]          = B.overflow_out; \
  assign drop_w[I]         = B.drop_count_out;

  `HOOK(bus_c, 0)
  `HOOK(bus_l, 1)
  `HOOK(bus_g, 2)
`undef HOOK

  uart_echo_ctrl #(.DATA_BITS(DB), .DEPTH(DEP), .MODE(0), .TERM_CHAR(8'h0D),
                   .GAP_CYCLES(0), .CNT_BITS(CB))
    u_char (.sysclk(sysclk), .rst_in(rst), .bus(bus_c));
  uart_echo_ctrl #(.DATA_BITS(DB), .DEPTH(DEP), .MODE(1), .TERM_CHAR(8'h0D),
                   .GAP_CYCLES(0), .CNT_BITS(CB))
    u_line (.sysclk(sysclk), .rst_in(rst), .bus(bus_l));
  uart_echo_ctrl #(.DATA_BITS(DB), .DEPTH(DEP), .MODE(0), .TERM_CHAR(8'h0D),
                   .GAP_CYCLES(GAP), .CNT_BITS(CB))
    u_gap (.sysclk(sysclk), .rst_in(rst), .bus(bus_g));

  // TX model: each start is answered by a one-cycle done pulse done_lat cycles later.
  int         done_lat = 100;
  int         dcnt [3] = '{0, 0, 0};
  int         act = 0;
  logic [7:0] got_q [$];
  int         start_q [$];
  int         done_q [$];

  always @(posedge sysclk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        dcnt[i]   = 0;
        done_r[i] = 1'b0;
      end else begin
        done_r[i] = (dcnt[i] == 1);
        if (done_r[i] && i == act) done_q.push_back(cyc);
        if (dcnt[i] != 0) dcnt[i]--;
        if (start_w[i]) begin
          dcnt[i] = done_lat;
          if (i == act) begin
            got_q.push_back(txd_w[i]);
            start_q.push_back(cyc);
          end
        end
      end
    end
  end

  // Reference model: bytes accepted into the FIFO in order, plus dropped-write count.
  logic [7:0] exp_q [$];
  int         m_drops = 0;
  int         last_wr_edge = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  int         w0 = 0;
  int         base = 0;
  logic [7:0] b = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input int hold);
    @(negedge sysclk);
    rx_data      = d;
    rx_valid     = 1'b1;
    last_wr_edge = cyc + 1;
    if (exp_q.size() - got_q.size() < DEP) exp_q.push_back(d);
    else m_drops++;
    repeat (hold) @(negedge sysclk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge sysclk);
      k++;
    end
    chk(tag, 32'(got_q.size()), 32'(n));
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    start_q.delete();
    done_q.delete();
    m_drops = 0;
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    rst = 1'b1; en = 3'b000; rx_valid = 1'b0; clr = 1'b0;
    idle(2);
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    idle(3);
    chk("rst_txd",   32'(txd_w[0]),   32'h00);
    chk("rst_start", 32'(start_w[0]), 32'h0);
    chk("rst_level", 32'(lvl_w[0]),   32'h0);
    chk("rst_empty", 32'(empty_w[0]), 32'h1);
    chk("rst_full",  32'(full_w[0]),  32'h0);
    chk("rst_ovf",   32'(ovf_w[0]),   32'h0);
    chk("rst_drop",  32'(drop_w[0]),  32'h0);
    rst = 1'b0;

    // Char mode: three bytes echoed in order, first start two cycles after the write.
    act = 0; done_lat = 100; en = 3'b001;
    send(8'h41, 1); w0 = last_wr_edge;
    send(8'h42, 1);
    send(8'h43, 1);
    wait_got(3, 1000, "p1_starts");
    cmp_stream("p1_data");
    chk("p1_first_lat", 32'((start_q.size() > 0) ? start_q[0] - w0 : -1), 32'd2);
    chk("p1_done_to_start", 32'((start_q.size() > 1 && done_q.size() > 0) ? start_q[1] - done_q[0] : -1), 32'd3);
    idle(120);
    chk("p1_level", 32'(lvl_w[0]), 32'h0);
    chk("p1_empty", 32'(empty_w[0]), 32'h1);

    // rx_valid held high for 10 cycles is a single write.
    en = 3'b000;
    send(8'h55, 10);
    idle(2);
    chk("p2_level", 32'(lvl_w[0]), 32'h1);
    en = 3'b001;
    idle(250);
    cmp_stream("p2_data");
    chk("p2_drop", 32'(drop_w[0]), 32'(m_drops));

    // Fill with draining disabled, overflow once, then drain all 16.
    en = 3'b000; base = got_q.size();
    for (int i = 0; i < 16; i++) send(8'(i), 1);
    idle(1);
    chk("p3_full",  32'(full_w[0]), 32'h1);
    chk("p3_level", 32'(lvl_w[0]),  32'd16);
    send(8'h10, 1);
    idle(1);
    chk("p3_ovf",      32'(ovf_w[0]),  32'h1);
    chk("p3_drop",     32'(drop_w[0]), 32'(m_drops));
    chk("p3_nostarts", 32'(got_q.size()), 32'(base));
    en = 3'b001;
    wait_got(base + 16, 3000, "p3_starts");
    cmp_stream("p3_data");
    idle(120);
    chk("p3_empty", 32'(empty_w[0]), 32'h1);
    @(negedge sysclk); clr = 1'b1;
    @(negedge sysclk); clr = 1'b0;
    m_drops = 0;
    chk("p3_clr_drop", 32'(drop_w[0]), 32'(m_drops));
    chk("p3_clr_ovf",  32'(ovf_w[0]),  32'h0);

    // Clear in the same cycle as a dropped write wins.
    en = 3'b000;
    for (int i = 0; i < 16; i++) send(8'(8'hA0 + i), 1);
    @(negedge sysclk); rx_data = 8'h99; rx_valid = 1'b1; clr = 1'b1;
    @(negedge sysclk); rx_valid = 1'b0; clr = 1'b0;
    chk("p3_clr_prio", 32'(drop_w[0]), 32'(m_drops));
    send(8'hAA, 1);
    idle(1);
    chk("p3_drop_after_clr", 32'(drop_w[0]), 32'(m_drops));

    // Line mode: held until terminator, then flushed when full without one.
    do_reset();
    act = 1; done_lat = 20; en = 3'b010;
    send(8'h41, 1);
    send(8'h42, 1);
    idle(30);
    chk("p4_held",       32'(got_q.size()), 32'd0);
    chk("p4_held_level", 32'(lvl_w[1]),     32'd2);
    send(8'h0D, 1);
    wait_got(3, 300, "p4_line_starts");
    cmp_stream("p4_line");
    idle(40);
    chk("p4_pending", 32'(u_line.pending_lines), 32'd0);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h0D) b = 8'h0E;
      send(b, 1);
      if (i == 14) begin
        idle(5);
        chk("p4_hold15", 32'(got_q.size()), 32'd3);
      end
    end
    wait_got(19, 1200, "p4_flush_starts");
    cmp_stream("p4_flush");
    idle(40);
    chk("p4_flush_empty", 32'(empty_w[1]), 32'h1);

    // Inter-byte gap.
    do_reset();
    act = 2; done_lat = 30; en = 3'b100;
    send(8'($urandom_range(0, 255)), 1);
    send(8'($urandom_range(0, 255)), 1);
    wait_got(2, 400, "p5_starts");
    cmp_stream("p5_data");
    chk("p5_gap", 32'((start_q.size() > 1 && done_q.size() > 0) ? start_q[1] - done_q[0] : -1),
        32'(1 + GAP + 2));

    // Asynchronous reset while waiting for done with 4 bytes still queued.
    do_reset();
    act = 0; done_lat = 100; en = 3'b000;
    for (int i = 0; i < 5; i++) send(8'($urandom_range(1, 255)), 1);
    en = 3'b001;
    wait_got(1, 50, "p6_first");
    idle(5);
    chk("p6_level_pre", 32'(lvl_w[0]), 32'd4);
    @(negedge sysclk);
    #2 rst = 1'b1;
    #1;
    chk("p6_arst_txd",   32'(txd_w[0]),   32'h00);
    chk("p6_arst_start", 32'(start_w[0]), 32'h0);
    chk("p6_arst_level", 32'(lvl_w[0]),   32'h0);
    chk("p6_arst_empty", 32'(empty_w[0]), 32'h1);
    idle(2);
    rst = 1'b0;
    clear_model();
    en = 3'b001;
    send(8'h7E, 1);
    wait_got(1, 100, "p6_echo");
    cmp_stream("p6_data");

    // Randomized traffic with random enable toggling; outstanding bytes kept below depth.
    done_lat = $urandom_range(2, 12);
    for (int i = 0; i < 60; i++) begin
      int bound;
      bound = 0;
      while (exp_q.size() - got_q.size() >= DEP && bound < 2000) begin
        en[0] = 1'b1;
        @(negedge sysclk);
        bound++;
      end
      if ($urandom_range(0, 3) == 0) en[0] = ~en[0];
      send(8'($urandom_range(0, 255)), int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 3)) @(negedge sysclk);
    end
    en[0] = 1'b1;
    wait_got(exp_q.size(), 5000, "p7_all");
    cmp_stream("p7_data");
    chk("p7_drop", 32'(drop_w[0]), 32'(m_drops));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_echo_ctrl.md
# uart_echo_ctrl

Parametrised echo controller between a UART receiver and transmitter: buffers received bytes in an internal synchronous FIFO and re-issues them to the transmitter with a strict start/done handshake. Successor to the fixed 8-bit, read-when-full echo top level. Adds configurable width and depth, a per-character or per-line release mode, edge-qualified RX writes, inter-byte gap timing, and overflow accounting. Sits directly under the board top, between `uart` RX outputs and TX inputs.

## Interface
- `DATA_BITS`, 8, byte width for RX, TX and FIFO
- `DEPTH`, 16, FIFO entries; power of two, >= 2
- `MODE`, 0, 0 = char mode (drain whenever not empty), 1 = line mode (drain only after a terminator is stored)
- `TERM_CHAR`, 8'h0D, line-mode terminator (low `DATA_BITS` bits)
- `GAP_CYCLES`, 0, idle sysclk cycles after each `tx_done_in` before the next start
- `CNT_BITS`, 16, width of the dropped-byte counter
- `sysclk`  in  1  system clock, all logic on rising edge
- `rst_in`  in  1  reset, asynchronous, active-high
- `rx_data_in`  in  DATA_BITS  received byte, valid while `rx_valid_in` is high
- `rx_valid_in`  in  1  RX data-ready, level or pulse; only its rising edge writes
- `tx_done_in`  in  1  one-cycle pulse from TX at end of stop bit
- `enable_in`  in  1  1 = draining allowed; RX buffering is unaffected
- `clr_overflow_in`  in  1  synchronous clear of `overflow_out` and `drop_count_out`
- `tx_data_out`  out  DATA_BITS  byte to transmit, registered
- `tx_start_out`  out  1  one-cycle start pulse to TX
- `fifo_level_out`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `full_out` / `empty_out`  out  1  level == DEPTH / level == 0
- `overflow_out`  out  1  sticky, set when a write is dropped
- `drop_count_out`  out  CNT_BITS  dropped writes, saturating at all-ones

## Operation
- Reset values: `tx_data_out` 0, `tx_start_out` 0, level 0, `empty_out` 1, `full_out` 0, `overflow_out` 0, `drop_count_out` 0, internal `rx_valid` history 0, pointers 0, `pending_lines` 0, flush 0, state IDLE.
- Write: a cycle with `rx_valid_in`=1 and the registered previous value =0 is a write event. If not full, `rx_data_in` is stored and the write pointer increments, wrapping at DEPTH. If full, the byte is dropped, `overflow_out` is set, and `drop_count_out` increments, saturating. A simultaneous pop does not rescue a write to a full FIFO.
- Line mode: `pending_lines` increments on every stored `TERM_CHAR` and decrements on every popped `TERM_CHAR`. Both in one cycle leave it unchanged. If the FIFO is full while `pending_lines`=0, the flush flag is set; it clears when the FIFO becomes empty.
- Eligible to drain: `enable_in`=1 and not empty and (MODE=0 or `pending_lines`>0 or flush).
- FSM:
  - IDLE: if eligible, pop the head into `tx_data_out`, advance the read pointer, and go to START.
  - START: assert `tx_start_out` for one cycle and go to WAIT.
  - WAIT: on `tx_done_in`, go to GAP if `GAP_CYCLES`>0, else go to IDLE.
  - GAP: count `GAP_CYCLES` cycles, then go to IDLE.
- `tx_done_in` is ignored outside WAIT. `enable_in` is sampled only in IDLE; a transfer already started completes.
- `clr_overflow_in` takes priority over a same-cycle drop: the counter reads 0 afterwards.
- Level arithmetic: write-only +1, pop-only -1, both unchanged. The level never leaves 0..DEPTH.

## Timing
- Write event at edge N: the level updates at N. IDLE sees it at N+1 and loads `tx_data_out`. `tx_start_out` is high between edges N+2 and N+3.
- `tx_data_out` is stable from the load edge until the next load; TX may sample it while `tx_start_out` is high.
- The minimum start-to-start spacing is the TX frame time plus 1 + `GAP_CYCLES` + 2 cycles.
- `rst_in` asserted mid-transfer forces all outputs to their reset values immediately, without a clock. The pending byte and FIFO contents are discarded.
- `rx_valid_in` held high for many cycles produces exactly one write.

## Test plan
- Char mode, DEPTH=16: bytes 0x41, 0x42, 0x43 with a TX model returning `tx_done_in` 100 cycles after each start -> three starts carrying 0x41, 0x42, 0x43 in order. The first start occurs 2 cycles after the first write; level returns to 0.
- `rx_valid_in` held high 10 cycles with 0x55 -> level 1, one start only, `drop_count_out` 0.
- `enable_in`=0 and 17 writes 0x00..0x10 -> `full_out`=1 after 16 writes, `overflow_out`=1, `drop_count_out`=1, no starts. Then `enable_in`=1 -> 16 starts carrying 0x00..0x0F, then `empty_out`=1. Then `clr_overflow_in` -> counter 0.
- Line mode: write "AB" with no start, then 0x0D -> starts for 0x41, 0x42, 0x0D, then `pending_lines`=0. Writing 16 non-terminator bytes -> flush drains all 16.
- `GAP_CYCLES`=5: consecutive bytes -> exactly 1 + 5 + 2 cycles from `tx_done_in` to the next `tx_start_out`.
- `rst_in` pulsed while in WAIT with 4 bytes queued -> outputs at reset values asynchronously, level 0. After release, a new byte 0x7E echoes normally with wrap-around intact.
